// File: rtl/dsram_axi_pkg.sv
// rtl/dsram_axi_pkg.sv - shared state encoding and AXI3 constants for the data-side bridge
package dsram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_SINGLE = 4'd0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dsram_axi_bridge.sv
// rtl/dsram_axi_bridge.sv - data_sram load/store to single-beat AXI3 master
// Define DSRAM_POSTED_WRITE_EN to retire stores on AW/W completion and track B responses with a counter.
module dsram_axi_bridge
  import dsram_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         MAX_POSTED = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        pipe_stall,
  output logic        stallreq_axi,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CNT_W = (MAX_POSTED < 2) ? 1 : $clog2(MAX_POSTED + 1);

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;

  logic             is_load;
  logic             accept_rd, accept_wr;
  logic             rd_blocked, wr_blocked;
  logic             wr_both_done, wr_issued;
  logic [CNT_W-1:0] posted_cnt;

  assign arid    = AXI_ID;
  assign arlen   = LEN_SINGLE;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = AXI_ID;
  assign awlen   = LEN_SINGLE;
  assign awsize  = SIZE_WORD;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID;
  assign wlast   = 1'b1;

  assign araddr          = araddr_q;
  assign awaddr          = awaddr_q;
  assign wdata           = wdata_q;
  assign wstrb           = wstrb_q;
  assign arvalid         = arvalid_q;
  assign awvalid         = awvalid_q;
  assign wvalid          = wvalid_q;
  assign data_sram_rdata = rdata_q;

  // A channel counts as finished once its valid has dropped or is being accepted now.
  assign wr_both_done = (~awvalid_q | awready) & (~wvalid_q | wready);
  assign wr_issued    = (state_q == ST_WR_REQ) & wr_both_done;

  assign rd_blocked = (posted_cnt != '0);
  assign wr_blocked = (posted_cnt != '0) & (posted_cnt == CNT_W'(MAX_POSTED));

  assign is_load   = (data_sram_we == 4'b0000);
  assign accept_rd = (state_q == ST_IDLE) & data_sram_en & is_load & ~rd_blocked;
  assign accept_wr = (state_q == ST_IDLE) & data_sram_en & ~is_load & ~wr_blocked;

`ifdef DSRAM_POSTED_WRITE_EN
  logic [CNT_W-1:0] posted_cnt_q, posted_cnt_d;
  logic             b_retire;

  assign b_retire = bvalid & (posted_cnt_q != '0);

  always_comb begin
    posted_cnt_d = posted_cnt_q;
    if (wr_issued && !b_retire) begin
      posted_cnt_d = posted_cnt_q + CNT_W'(1);
    end else if (!wr_issued && b_retire) begin
      posted_cnt_d = posted_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      posted_cnt_q <= '0;
    end else begin
      posted_cnt_q <= posted_cnt_d;
    end
  end

  assign posted_cnt = posted_cnt_q;
  assign bready     = 1'b1;
`else
  assign posted_cnt = '0;
  assign bready     = (state_q == ST_WR_RESP);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_rd) begin
          state_d = ST_RD_ADDR;
        end else if (accept_wr) begin
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_ADDR: if (arvalid_q && arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (rvalid) state_d = ST_DONE;
      ST_WR_REQ: begin
        if (wr_both_done) begin
`ifdef DSRAM_POSTED_WRITE_EN
          state_d = ST_DONE;
`else
          state_d = ST_WR_RESP;
`endif
        end
      end
      ST_WR_RESP: if (bvalid) state_d = ST_DONE;
      // Holding in DONE keeps a frozen pipeline from re-presenting the same request.
      ST_DONE: if (!pipe_stall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q & ~arready;
    awvalid_d = awvalid_q & ~awready;
    wvalid_d  = wvalid_q & ~wready;
    if (accept_rd) begin
      araddr_d  = word_align(data_sram_addr);
      arvalid_d = 1'b1;
    end
    if (accept_wr) begin
      awaddr_d  = word_align(data_sram_addr);
      wdata_d   = data_sram_wdata;
      wstrb_d   = data_sram_we;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end
    if ((state_q == ST_RD_DATA) && rvalid) begin
      rdata_d = rdata;
    end
    rready       = (state_q == ST_RD_DATA);
    stallreq_axi = ((state_q == ST_IDLE) & data_sram_en)
                 | (state_q == ST_RD_ADDR) | (state_q == ST_RD_DATA)
                 | (state_q == ST_WR_REQ)  | (state_q == ST_WR_RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// tb/tb_dsram_axi_bridge.sv - directed scoreboard bench for dsram_axi_bridge
// Posted-write scenario runs only when DSRAM_POSTED_WRITE_EN is defined.
module tb_dsram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        pipe_stall = 1'b0;
  logic        stallreq_axi;
  logic [3:0]  arid, awid, wid, arlen, awlen, arcache, awcache;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic        rvalid = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = 32'h0;

  int vectors = 0;
  int miscompares = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0;
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_rd[$];
  logic [31:0] last_rd = 32'h0;
  logic        exp_bready;

  dsram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .pipe_stall(pipe_stall), .stallreq_axi(stallreq_axi),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Handshakes sampled mid-cycle; every beat must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn) begin
      if (arvalid && arready) begin
        ar_hs++;
        if (exp_ar.size() == 0) check("ar_extra_beat", 64'd1, 64'd0);
        else check("araddr", {32'h0, araddr}, {32'h0, exp_ar.pop_front()});
      end
      if (awvalid && awready) begin
        aw_hs++;
        if (exp_aw.size() == 0) check("aw_extra_beat", 64'd1, 64'd0);
        else check("awaddr", {32'h0, awaddr}, {32'h0, exp_aw.pop_front()});
      end
      if (wvalid && wready) begin
        w_hs++;
        if (exp_w.size() == 0) check("w_extra_beat", 64'd1, 64'd0);
        else check("wstrb_wdata", {28'h0, wstrb, wdata}, {28'h0, exp_w.pop_front()});
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input int ar_wait, input int r_wait, input int hold);
    int cyc, arw, rw, n0;
    bit rdone;
    cyc = 0; arw = ar_wait; rw = r_wait; rdone = 0; n0 = ar_hs;
    exp_ar.push_back({addr[31:2], 2'b00});
    exp_rd.push_back(data);
    data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = addr; data_sram_wdata = 32'hDEAD_BEEF;
    #1 check("rd_req_stall", {63'h0, stallreq_axi}, 64'd1);
    while (!rdone && cyc < 40) begin
      tick(); cyc++;
      arready = 1'b0; rvalid = 1'b0;
      if (arvalid) begin if (arw == 0) arready = 1'b1; else arw--; end
      if (rready) begin
        if (rw == 0) begin rvalid = 1'b1; rdata = data; rdone = 1; end
        else rw--;
      end
      #1 check("rd_busy_stall", {63'h0, stallreq_axi}, 64'd1);
    end
    check("rd_done_seen", {63'h0, rdone}, 64'd1);
    check("rd_latency", 64'(cyc), 64'(2 + ar_wait + r_wait));
    tick();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0BAD_0BAD;
    last_rd = exp_rd.pop_front();
    pipe_stall = (hold > 1);
    data_sram_en = (hold > 1);
    #1 check("rd_done_stall", {63'h0, stallreq_axi}, 64'd0);
    check("rd_data", {32'h0, data_sram_rdata}, {32'h0, last_rd});
    for (int i = 1; i < hold; i++) begin
      tick();
      if (i == hold - 1) begin pipe_stall = 1'b0; data_sram_en = 1'b0; end
      #1 check("rd_hold_stall", {63'h0, stallreq_axi}, 64'd0);
      check("rd_hold_data", {32'h0, data_sram_rdata}, {32'h0, last_rd});
      check("rd_hold_no_ar", {63'h0, arvalid}, 64'd0);
    end
    tick();
    #1 check("rd_idle_stall", {63'h0, stallreq_axi}, 64'd0);
    check("rd_single_ar", 64'(ar_hs - n0), 64'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                          input int aw_wait, input int w_wait, input int b_wait, input bit give_b);
    int cyc, aww, ww, bw, n_aw, n_w;
    bit awd, wdn, fin;
    cyc = 0; aww = aw_wait; ww = w_wait; bw = b_wait; awd = 0; wdn = 0; fin = 0;
    n_aw = aw_hs; n_w = w_hs;
    exp_aw.push_back({addr[31:2], 2'b00});
    exp_w.push_back({we, wd});
    data_sram_en = 1'b1; data_sram_we = we; data_sram_addr = addr; data_sram_wdata = wd;
    #1 check("wr_req_stall", {63'h0, stallreq_axi}, 64'd1);
    while (!fin && cyc < 40) begin
      tick(); cyc++;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      if (awvalid) begin if (aww == 0) begin awready = 1'b1; awd = 1; end else aww--; end
      if (wvalid) begin if (ww == 0) begin wready = 1'b1; wdn = 1; end else ww--; end
`ifdef DSRAM_POSTED_WRITE_EN
      fin = awd && wdn;
`else
      if (bready) begin
        if (bw == 0) begin bvalid = 1'b1; fin = 1; end
        else bw--;
      end
`endif
      #1 check("wr_busy_stall", {63'h0, stallreq_axi}, 64'd1);
    end
    check("wr_done_seen", {63'h0, fin}, 64'd1);
`ifdef DSRAM_POSTED_WRITE_EN
    check("wr_latency", 64'(cyc), 64'(1 + ((aw_wait > w_wait) ? aw_wait : w_wait)));
`else
    check("wr_latency", 64'(cyc), 64'(2 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait));
`endif
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; data_sram_en = 1'b0;
`ifdef DSRAM_POSTED_WRITE_EN
    bvalid = give_b;
`endif
    #1 check("wr_done_stall", {63'h0, stallreq_axi}, 64'd0);
    check("wr_rdata_kept", {32'h0, data_sram_rdata}, {32'h0, last_rd});
    check("wr_done_valids", {62'h0, awvalid, wvalid}, 64'd0);
    tick();
    bvalid = 1'b0;
    #1 check("wr_idle_stall", {63'h0, stallreq_axi}, 64'd0);
    check("wr_single_aw", 64'(aw_hs - n_aw), 64'd1);
    check("wr_single_w", 64'(w_hs - n_w), 64'd1);
  endtask

  initial begin
`ifdef DSRAM_POSTED_WRITE_EN
    exp_bready = 1'b1;
`else
    exp_bready = 1'b0;
`endif
    #12;
    check("rst_valids", {60'h0, arvalid, awvalid, wvalid, rready}, 64'd0);
    check("rst_bready", {63'h0, bready}, {63'h0, exp_bready});
    check("rst_stall", {63'h0, stallreq_axi}, 64'd0);
    check("rst_addrs", {araddr, awaddr}, 64'd0);
    check("rst_wdata_strb", {28'h0, wstrb, wdata}, 64'd0);
    check("rst_rdata", {32'h0, data_sram_rdata}, 64'd0);
    check("fixed_fields", {52'h0, arsize, awsize, arburst, awburst, wlast, arlen[0], awlen[0]},
          {52'h0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0});
    check("axi_ids", {52'h0, arid, awid, wid}, {52'h0, 4'd1, 4'd1, 4'd1});
    tick();
    resetn = 1'b1;
    tick();

    do_read(32'h1C00_0006, 32'hA1B2_C3D4, 0, 2, 0);
    do_read(32'h0000_0010, 32'h1122_3344, 0, 0, 0);
    do_read(32'h8000_0FFB, 32'h5566_7788, 2, 1, 0);
    do_write(32'h2000_0002, 4'b0100, 32'h00EE_0000, 0, 0, 2, 1);
    do_write(32'h2000_0010, 4'b1111, 32'hCAFE_1234, 0, 3, 0, 1);
    do_write(32'h2000_0021, 4'b0011, 32'h0000_BEEF, 3, 0, 1, 1);
    do_write(32'h2000_0033, 4'b1000, 32'h7700_0000, 1, 1, 0, 1);
    do_read(32'h0000_0FFF, 32'hCAFE_F00D, 1, 0, 4);

    // Reset while waiting on R: everything must go quiet immediately.
    exp_ar.push_back(32'h3000_0040);
    data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h3000_0042;
    tick();
    arready = arvalid;
    tick();
    arready = 1'b0;
    #1 check("rst_mid_rready_pre", {63'h0, rready}, 64'd1);
    resetn = 1'b0; data_sram_en = 1'b0;
    #1 check("rst_mid_now", {61'h0, arvalid, rready, stallreq_axi}, 64'd0);
    tick();
    #1 check("rst_mid_next", {61'h0, arvalid, rready, stallreq_axi}, 64'd0);
    check("rst_mid_rdata", {32'h0, data_sram_rdata}, 64'd0);
    last_rd = 32'h0;
    resetn = 1'b1;
    tick();
    do_read(32'h4000_0008, 32'h0F0F_F0F0, 0, 0, 1);

`ifdef DSRAM_POSTED_WRITE_EN
    for (int k = 0; k < 4; k++) begin
      do_write(32'h5000_0000 + 32'(k * 4), 4'hF, 32'h1000_0000 + 32'(k), 0, 0, 0, 0);
    end
    data_sram_en = 1'b1; data_sram_we = 4'hF; data_sram_addr = 32'h5000_0010;
    data_sram_wdata = 32'h1000_0004;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1 check("pw_fifth_blocked", {62'h0, awvalid, stallreq_axi}, 64'd1);
    end
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    do_write(32'h5000_0010, 4'hF, 32'h1000_0004, 0, 0, 0, 0);
    data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h6000_0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      bvalid = 1'b1;
      #1 check("pw_rd_blocked_b", {62'h0, arvalid, stallreq_axi}, 64'd1);
      tick();
      bvalid = 1'b0;
      #1 check("pw_rd_blocked_gap", {62'h0, arvalid, stallreq_axi}, 64'd1);
    end
    do_read(32'h6000_0000, 32'h9999_AAAA, 0, 0, 0);
`endif

    tick();
    check("queues_drained", 64'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rd.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dsram_axi_bridge.md
Name: dsram_axi_bridge

Overview:
- Data-side responder for the CPU's data_sram interface: accepts the load/store request issued by the execute stage and performs the access as a single-beat AXI3 master transaction.
- Returns load data on data_sram_rdata for the memory stage's byte/halfword extraction.
- Raises stallreq_axi to hold the pipeline while a transaction is in flight.
- Sits between the execute/memory stages and the top-level AXI crossbar.

Parameters:
AXI_ID, 4'd1, ID driven on arid/awid/wid.
MAX_POSTED, 4, maximum outstanding posted writes; used only when DSRAM_POSTED_WRITE_EN is defined.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
data_sram_en  in  1  request valid from execute stage
data_sram_we  in  4  byte write enables; 0 = load
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  store data, byte-lane aligned
data_sram_rdata  out  32  load data, word-aligned
pipe_stall  in  1  pipeline held by a source other than this block
stallreq_axi  out  1  hold pipeline
arvalid/arready  out/in  1/1  read address handshake
araddr  out  32  read address
rdata  in  32  read data
rvalid/rready  in/out  1/1  read data handshake
awvalid/awready  out/in  1/1  write address handshake
awaddr  out  32  write address
wvalid/wready  out/in  1/1  write data handshake
wdata  out  32  write data
wstrb  out  4  write byte strobes
bvalid/bready  in/out  1/1  write response handshake

Fixed AXI fields are driven as constants and are not listed above: arlen/awlen=0, arsize/awsize=3'b010, burst=2'b01, wlast=1, lock/cache/prot=0.

Behaviour:
- Reset values:
  - State IDLE.
  - All valid/ready outputs 0.
  - araddr, awaddr, wdata, wstrb, data_sram_rdata = 0.
  - stallreq_axi = 0.
- Accept: in IDLE, data_sram_en=1 latches addr, we, wdata in the same cycle.
- Read path (we==0):
  - IDLE → RD_ADDR. araddr = {addr[31:2],2'b00}; arvalid asserted next cycle.
  - RD_ADDR: on arvalid&arready, drop arvalid → RD_DATA.
  - RD_DATA: rready=1. On rvalid, capture rdata into data_sram_rdata → DONE.
- Write path (we!=0):
  - IDLE → WR_REQ. awvalid and wvalid both asserted; awaddr = addr unaligned-cleared to word; wstrb = we.
  - WR_REQ: each valid drops independently on its own handshake. When both channels have completed, in any order or in the same cycle → WR_RESP.
  - WR_RESP: bready=1. On bvalid → DONE.
- DONE:
  - stallreq_axi=0.
  - If pipe_stall=1, remain in DONE and ignore data_sram_en, so the held request is not reissued.
  - Else → IDLE.
- stallreq_axi = (IDLE & data_sram_en) | RD_ADDR | RD_DATA | WR_REQ | WR_RESP. This is combinational, so the pipeline freezes in the request cycle.
- Latency: a load with zero-wait slave completes in DONE three cycles after accept.
- data_sram_rdata holds its value until the next read completes; writes do not change it.
- rresp/bresp are ignored.
- resetn deasserted mid-transaction: immediate return to IDLE, all valids cleared. An outstanding slave beat after reset is not consumed.

Optional Feature:
DSRAM_POSTED_WRITE_EN
- Defined:
  - Writes go to DONE once both AW and W handshakes have completed; WR_RESP is skipped.
  - bready is held at 1 permanently.
  - A counter tracks outstanding B responses: increment on write completion, decrement on bvalid, simultaneous events net zero.
  - A new write stalls in IDLE while the count equals MAX_POSTED.
  - A read stalls in IDLE until the count is 0.
- Undefined: the counter is absent and every write waits for B, as described above.

Decomposition:
- Package dsram_axi_pkg:
  - State encoding (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE).
  - AXI constants: SIZE_WORD, BURST_INCR, LEN_SINGLE.
- No sub-module; the FSM and datapath form one unit. The posted-write counter is a local always block.

Test Plan:
- Load at 0x1C00_0006, slave returns 0xA1B2_C3D4 after 2 wait cycles → araddr = 0x1C00_0004; data_sram_rdata = 0xA1B2C3D4 in DONE; stallreq_axi high from accept until DONE.
- Store we=4'b0100, wdata=0x00EE_0000 → wstrb = 0100; wdata matches; stall drops only after bvalid.
- Store with awready 3 cycles before wready, then the reverse order → one handshake per channel; no duplicate valids.
- Load completes while pipe_stall=1 for 4 cycles with data_sram_en held → exactly one AR issued; rdata stable.
- resetn asserted while in RD_DATA → next cycle arvalid=0, rready=0, stallreq_axi=0.
- DSRAM_POSTED_WRITE_EN, bvalid withheld → five back-to-back stores: the fifth stalls at count 4. A following load waits until all four B responses have returned.
